register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Parameters
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning the width of each register and each data port.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 6, meaning the width of each address port.
REQ-003 The block SHALL have parameter DEPTH, default 2**ADDR_WIDTH (64), meaning the number of registers.

Interface
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  system clock; all state updates occur on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-high reset (asserted at 1).
REQ-007 read_en  input  2  per-port read enables; bit 0 enables port 0, bit 1 enables port 1.
REQ-008 write_en  input  1  write enable for the single write port.
REQ-009 raddr_0  input  ADDR_WIDTH  read address for port 0.
REQ-010 raddr_1  input  ADDR_WIDTH  read address for port 1.
REQ-011 waddr  input  ADDR_WIDTH  write address.
REQ-012 wdata  input  DATA_WIDTH  write data.
REQ-013 rdata_0  output  DATA_WIDTH  read data for port 0.
REQ-014 rdata_1  output  DATA_WIDTH  read data for port 1.

Function
REQ-015 Storage SHALL be DEPTH independent DATA_WIDTH-bit registers, addressed 0..DEPTH-1.
REQ-016 No register is hardwired; register 0 SHALL be writable and readable like every other register.
REQ-017 Write: on a rising clk edge with write_en=1 and reset_n=0, register[waddr] SHALL load wdata.
REQ-018 A write SHALL update only register[waddr]; all other registers SHALL be unchanged.
REQ-019 When write_en=0, no register SHALL change.
REQ-020 Read port 0 SHALL be combinational (zero-cycle latency): rdata_0 = register[raddr_0] when read_en[0]=1, else all zeros.
REQ-021 Read port 1 SHALL be combinational (zero-cycle latency): rdata_1 = register[raddr_1] when read_en[1]=1, else all zeros.
REQ-022 The two read ports SHALL be fully independent, and both SHALL be able to read the same or different addresses in the same cycle.
REQ-023 Write-then-read timing: a value written at rising edge N SHALL be visible on an enabled read port addressing it immediately after edge N, with no extra cycle.
REQ-024 Read during write to the same address: before the edge the read SHALL return the old contents, and after the edge the new contents (no write-to-read bypass).
REQ-025 Overwriting the same register repeatedly SHALL always leave the last written value; there is no accumulation or merging.
REQ-026 All addresses are in range for DEPTH=2**ADDR_WIDTH; address arithmetic SHALL NOT wrap or alias.

Reset
REQ-027 While reset_n=1, all DEPTH registers SHALL be cleared to 0 asynchronously, without waiting for a clk edge.
REQ-028 While reset_n=1, writes SHALL be ignored.
REQ-029 Outputs SHALL follow REQ-020 and REQ-021 during reset, so an enabled read returns 0 and a disabled read returns 0.
REQ-030 Reset asserted mid-operation SHALL clear all registers immediately, including a write in progress in that cycle.
REQ-031 After reset_n returns to 0, the first rising edge SHALL accept writes.

Verification
REQ-032 The bench SHALL cover reset clearing: write 0xDEADBEEF_CAFEF00D to addr 5, assert reset_n=1 between edges, read addr 5 with read_en=2'b01 -> rdata_0 = 0 immediately.
REQ-033 The bench SHALL cover exhaustive write/readback: for each addr 0..63, write 64 random values one per cycle; after each write read via port 0, then port 1, then both (read_en=2'b11) -> each enabled port equals the last wdata.
REQ-034 The bench SHALL cover write isolation: write addr k = k*0x0101010101010101 for all k, then read all 64 addresses on both ports -> each returns its own pattern.
REQ-035 The bench SHALL cover the read enable gate: register[3]=0x1234, raddr_0=raddr_1=3, read_en=2'b10 -> rdata_0=0 and rdata_1=0x1234; read_en=2'b01 -> the reverse.
REQ-036 The bench SHALL cover same-cycle read/write: register[7]=0xA, write 0xB to addr 7 while reading 7 -> 0xA before the edge, 0xB after it.
REQ-037 The bench SHALL cover write_en=0: set wdata=0xFFFF and waddr=9, hold write_en=0, clock one edge -> register[9] is unchanged.

Source files
------------

// File: rtl/register_file.sv
// register_file
//   Register array with DEPTH words of DATA_WIDTH bits each. It has one synchronous
//   write port and two independent combinational read ports. A disabled read port
//   drives all zeros.
//
// Ports
//   clk      in   system clock; all state changes happen on its rising edge
//   reset_n  in   asynchronous reset, ACTIVE-HIGH despite the name. While it is 1,
//                 every register is held at 0 and writes are ignored.
//   read_en  in   [1:0] per-port read enable (bit 0 -> port 0, bit 1 -> port 1)
//   write_en in   write enable
//   raddr_0  in   [ADDR_WIDTH-1:0] port 0 read address
//   raddr_1  in   [ADDR_WIDTH-1:0] port 1 read address
//   waddr    in   [ADDR_WIDTH-1:0] write address
//   wdata    in   [DATA_WIDTH-1:0] write data
//   rdata_0  out  [DATA_WIDTH-1:0] port 0 read data (0 when disabled)
//   rdata_1  out  [DATA_WIDTH-1:0] port 1 read data (0 when disabled)
module register_file #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            read_en,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] raddr_0,
  input  logic [ADDR_WIDTH-1:0] raddr_1,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic [DATA_WIDTH-1:0] rdata_1
);

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];

  logic w_wr_hit;
  logic w_rd0_hit;
  logic w_rd1_hit;

  // DEPTH may be set below 2**ADDR_WIDTH. In that case, addresses past the end
  // are dropped on a write and read as zero, so they never alias onto a real
  // register.
  assign w_wr_hit  = write_en   && (32'(waddr)   < DEPTH);
  assign w_rd0_hit = read_en[0] && (32'(raddr_0) < DEPTH);
  assign w_rd1_hit = read_en[1] && (32'(raddr_1) < DEPTH);

  // Reset has priority over the clock. A write that is set up in the same cycle
  // that reset rises is lost.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_hit) begin
      r_regs[waddr] <= wdata;
    end
  end

  // The read ports have no write bypass. A read of the address being written
  // returns the old value until the edge.
  always_comb begin
    rdata_0 = '0;
    rdata_1 = '0;
    if (w_rd0_hit) rdata_0 = r_regs[raddr_0];
    if (w_rd1_hit) rdata_1 = r_regs[raddr_1];
  end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk;
  logic        reset_n;
  logic [1:0]  read_en;
  logic        write_en;
  logic [5:0]  raddr_0;
  logic [5:0]  raddr_1;
  logic [5:0]  waddr;
  logic [63:0] wdata;
  logic [63:0] rdata_0;
  logic [63:0] rdata_1;

  int checks = 0;
  int errors = 0;

  register_file #(.DATA_WIDTH(64), .ADDR_WIDTH(6)) dut (
    .clk(clk), .reset_n(reset_n), .read_en(read_en), .write_en(write_en),
    .raddr_0(raddr_0), .raddr_1(raddr_1), .waddr(waddr), .wdata(wdata),
    .rdata_0(rdata_0), .rdata_1(rdata_1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  ren;
    logic [5:0]  ra0;
    logic [5:0]  ra1;
    logic [63:0] e0;
    logic [63:0] e1;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [63:0] d);
    @(negedge clk);
    waddr    = a;
    wdata    = d;
    write_en = 1'b1;
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] ren, input logic [5:0] a0, input logic [5:0] a1);
    read_en = ren;
    raddr_0 = a0;
    raddr_1 = a1;
    #1;
  endtask

  initial begin
    logic [63:0] w;
    logic [63:0] pat;

    // Hand-computed expectations. State when the table runs: register k holds
    // k*0x0101010101010101, except register 3, which holds 0x1234.
    vecs[0] = '{2'b10, 6'd3,  6'd3,  64'h0,                 64'h1234};
    vecs[1] = '{2'b01, 6'd3,  6'd3,  64'h1234,              64'h0};
    vecs[2] = '{2'b00, 6'd3,  6'd3,  64'h0,                 64'h0};
    vecs[3] = '{2'b11, 6'd0,  6'd63, 64'h0,                 64'h3F3F3F3F3F3F3F3F};
    vecs[4] = '{2'b11, 6'd63, 6'd0,  64'h3F3F3F3F3F3F3F3F,  64'h0};
    vecs[5] = '{2'b11, 6'd1,  6'd2,  64'h0101010101010101,  64'h0202020202020202};
    vecs[6] = '{2'b11, 6'd42, 6'd42, 64'h2A2A2A2A2A2A2A2A,  64'h2A2A2A2A2A2A2A2A};
    vecs[7] = '{2'b10, 6'd5,  6'd32, 64'h0,                 64'h2020202020202020};
    vecs[8] = '{2'b01, 6'd16, 6'd33, 64'h1010101010101010,  64'h0};

    reset_n  = 1'b1;
    read_en  = 2'b00;
    write_en = 1'b0;
    raddr_0  = '0;
    raddr_1  = '0;
    waddr    = '0;
    wdata    = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rd(2'b11, 6'd0, 6'd63);
    chk("reset_rd0", rdata_0, 64'h0);
    chk("reset_rd1", rdata_1, 64'h0);
    @(negedge clk);
    reset_n = 1'b0;

    // Reset clears a register immediately, without waiting for an edge.
    do_write(6'd5, 64'hDEADBEEF_CAFEF00D);
    rd(2'b01, 6'd5, 6'd0);
    chk("pre_reset_addr5", rdata_0, 64'hDEADBEEF_CAFEF00D);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    chk("async_reset_addr5", rdata_0, 64'h0);

    // Writes are ignored while reset is held.
    waddr = 6'd6; wdata = 64'h55; write_en = 1'b1;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    rd(2'b01, 6'd6, 6'd0);
    chk("write_in_reset", rdata_0, 64'h0);

    // The first edge after reset is released accepts a write.
    @(negedge clk);
    reset_n = 1'b0;
    waddr = 6'd5; wdata = 64'h0123456789ABCDEF; write_en = 1'b1;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    rd(2'b11, 6'd5, 6'd5);
    chk("first_edge_write", rdata_0, 64'h0123456789ABCDEF);

    // Exhaustive write/readback on every address, checked on each port and on both.
    for (int a = 0; a < 64; a++) begin
      for (int n = 0; n < 64; n++) begin
        w = {$urandom(), $urandom()};
        do_write(6'(a), w);
        rd(2'b01, 6'(a), 6'(a));
        chk("exh_p0", rdata_0, w);
        chk("exh_p0_dis1", rdata_1, 64'h0);
        rd(2'b10, 6'(a), 6'(a));
        chk("exh_p1", rdata_1, w);
        chk("exh_p1_dis0", rdata_0, 64'h0);
        rd(2'b11, 6'(a), 6'(a));
        chk("exh_both0", rdata_0, w);
        chk("exh_both1", rdata_1, w);
      end
    end

    // Each address holds its own pattern, so writes do not disturb other registers.
    for (int k = 0; k < 64; k++) do_write(6'(k), 64'(k) * 64'h0101010101010101);
    for (int k = 0; k < 64; k++) begin
      pat = 64'(k) * 64'h0101010101010101;
      rd(2'b11, 6'(k), 6'(63 - k));
      chk("iso_p0", rdata_0, pat);
      chk("iso_p1", rdata_1, 64'(63 - k) * 64'h0101010101010101);
    end

    // Read-enable gating and mixed-address reads, driven from the table.
    do_write(6'd3, 64'h1234);
    for (int i = 0; i < 9; i++) begin
      rd(vecs[i].ren, vecs[i].ra0, vecs[i].ra1);
      chk($sformatf("vec%0d_rd0", i), rdata_0, vecs[i].e0);
      chk($sformatf("vec%0d_rd1", i), rdata_1, vecs[i].e1);
    end

    // Read during a write to the same address: old value before the edge, new after.
    do_write(6'd7, 64'hA);
    @(negedge clk);
    waddr = 6'd7; wdata = 64'hB; write_en = 1'b1;
    rd(2'b11, 6'd7, 6'd7);
    chk("rdw_before0", rdata_0, 64'hA);
    chk("rdw_before1", rdata_1, 64'hA);
    @(posedge clk);
    #1;
    write_en = 1'b0;
    chk("rdw_after0", rdata_0, 64'hB);
    chk("rdw_after1", rdata_1, 64'hB);

    // With write_en low, a clock edge leaves register 9 unchanged.
    @(negedge clk);
    waddr = 6'd9; wdata = 64'hFFFF; write_en = 1'b0;
    @(posedge clk);
    #1;
    rd(2'b01, 6'd9, 6'd0);
    chk("wen0_addr9", rdata_0, 64'h0909090909090909);

    // Repeated writes to one register leave only the last value.
    do_write(6'd10, 64'h1111);
    do_write(6'd10, 64'h2222);
    do_write(6'd10, 64'h0F0F);
    rd(2'b10, 6'd0, 6'd10);
    chk("overwrite_last", rdata_1, 64'h0F0F);

    // Reset raised mid-cycle drops the pending write and clears every register.
    @(negedge clk);
    waddr = 6'd12; wdata = 64'hCCCC; write_en = 1'b1;
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    rd(2'b11, 6'd12, 6'd63);
    chk("midop_reset_addr12", rdata_0, 64'h0);
    chk("midop_reset_addr63", rdata_1, 64'h0);
    rd(2'b11, 6'd0, 6'd10);
    chk("midop_reset_addr0", rdata_0, 64'h0);
    chk("midop_reset_addr10", rdata_1, 64'h0);
    @(negedge clk);
    reset_n = 1'b0;
    do_write(6'd0, 64'h77);
    rd(2'b01, 6'd0, 6'd0);
    chk("post_reset_addr0", rdata_0, 64'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
